// File: rtl/telemetry_framer_pkg.sv
// Shared ASCII framing constants and FSM state encoding for the telemetry framer.
package telemetry_framer_pkg;

  localparam logic [7:0] ASCII_LPAREN = 8'h28;
  localparam logic [7:0] ASCII_RPAREN = 8'h29;
  localparam logic [7:0] ASCII_STAR   = 8'h2A;
  localparam logic [7:0] ASCII_DOT    = 8'h2E;
  localparam logic [7:0] ASCII_CR     = 8'h0D;
  localparam logic [7:0] ASCII_LF     = 8'h0A;
  localparam logic [7:0] ASCII_ZERO   = 8'h30;
  // 'A' minus ten, so nibble values 10..15 land on 'A'..'F'
  localparam logic [7:0] ASCII_HEX_OFS = 8'h37;

  typedef enum logic [3:0] {
    IDLE,
    OPEN,
    DIGIT,
    DOT,
    CLOSE,
    STAR,
    CK_HI,
    CK_LO,
    CR,
    LF
  } state_t;

endpackage

// File: rtl/telemetry_hex_ascii.sv
// Combinational nibble to uppercase ASCII hex character converter.
module telemetry_hex_ascii
  import telemetry_framer_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) begin
      ascii = ASCII_ZERO + {4'h0, nibble};
    end else begin
      ascii = ASCII_HEX_OFS + {4'h0, nibble};
    end
  end

endmodule

// File: rtl/telemetry_framer.sv
// Serialises a snapshot of channel digits into an ASCII frame with XOR checksum
// over a valid/ready byte stream.
module telemetry_framer
  import telemetry_framer_pkg::*;
#(
  parameter int NUM_CH  = 5,
  parameter int DIGITS  = 6,
  parameter int DOT_POS = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [NUM_CH*DIGITS*8-1:0] ch_data,
  input  logic [NUM_CH-1:0]          dot_en,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DIG_W = $clog2(DIGITS + 1);
  localparam int SEL_W = $clog2(NUM_CH * DIGITS * 8);

  localparam logic [DIG_W-1:0] DOT_IDX  = DIG_W'(DIGITS - DOT_POS);
  localparam logic [DIG_W-1:0] LAST_DIG = DIG_W'(DIGITS);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

  state_t                     state_reg, state_next;
  logic [CH_W-1:0]            ch_idx_reg, ch_idx_next;
  logic [DIG_W-1:0]           dig_idx_reg, dig_idx_next;
  logic [7:0]                 cksum_reg, cksum_next;
  logic [NUM_CH*DIGITS*8-1:0] ch_snap_reg;
  logic [NUM_CH-1:0]          dot_snap_reg;
  logic                       frame_done_reg, frame_done_next;
  logic                       load_snap;

  logic                       xfer;
  logic [DIG_W-1:0]           dig_inc;
  logic [SEL_W-1:0]           bit_base;
  logic [7:0]                 cur_digit;
  logic                       dot_on;
  logic [3:0]                 nibble_sel;
  logic [7:0]                 hex_char;
  logic [7:0]                 tx_byte;

  assign tx_valid   = (state_reg != IDLE);
  assign busy       = (state_reg != IDLE);
  assign frame_done = frame_done_reg;
  assign tx_data    = tx_byte;
  assign xfer       = tx_valid && tx_ready;

  assign dig_inc   = dig_idx_reg + DIG_W'(1);
  assign bit_base  = SEL_W'((int'(ch_idx_reg) * DIGITS + int'(dig_idx_reg)) * 8);
  assign cur_digit = ch_snap_reg[bit_base +: 8];
  assign dot_on    = (DOT_POS > 0) && dot_snap_reg[ch_idx_reg];

  // The checksum is complete once STAR is reached, so both hex states read the final value.
  assign nibble_sel = (state_reg == CK_HI) ? cksum_reg[7:4] : cksum_reg[3:0];

  telemetry_hex_ascii u_hex (
    .nibble (nibble_sel),
    .ascii  (hex_char)
  );

  always_comb begin
    state_next      = state_reg;
    ch_idx_next     = ch_idx_reg;
    dig_idx_next    = dig_idx_reg;
    cksum_next      = cksum_reg;
    frame_done_next = 1'b0;
    load_snap       = 1'b0;
    tx_byte         = 8'h00;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next   = OPEN;
          ch_idx_next  = '0;
          dig_idx_next = '0;
          cksum_next   = 8'h00;
          load_snap    = 1'b1;
        end
      end
      OPEN: begin
        tx_byte = ASCII_LPAREN;
        if (xfer) begin
          cksum_next   = cksum_reg ^ ASCII_LPAREN;
          dig_idx_next = '0;
          state_next   = DIGIT;
        end
      end
      DIGIT: begin
        tx_byte = cur_digit;
        if (xfer) begin
          cksum_next   = cksum_reg ^ cur_digit;
          dig_idx_next = dig_inc;
          if (dig_inc == DOT_IDX && dot_on) begin
            state_next = DOT;
          end else if (dig_inc == LAST_DIG) begin
            state_next = CLOSE;
          end else begin
            state_next = DIGIT;
          end
        end
      end
      DOT: begin
        tx_byte = ASCII_DOT;
        if (xfer) begin
          cksum_next = cksum_reg ^ ASCII_DOT;
          state_next = DIGIT;
        end
      end
      CLOSE: begin
        tx_byte = ASCII_RPAREN;
        if (xfer) begin
          cksum_next = cksum_reg ^ ASCII_RPAREN;
          if (ch_idx_reg < LAST_CH) begin
            ch_idx_next = ch_idx_reg + CH_W'(1);
            state_next  = OPEN;
          end else begin
            state_next = STAR;
          end
        end
      end
      STAR: begin
        tx_byte = ASCII_STAR;
        if (xfer) state_next = CK_HI;
      end
      CK_HI: begin
        tx_byte = hex_char;
        if (xfer) state_next = CK_LO;
      end
      CK_LO: begin
        tx_byte = hex_char;
        if (xfer) state_next = CR;
      end
      CR: begin
        tx_byte = ASCII_CR;
        if (xfer) state_next = LF;
      end
      LF: begin
        tx_byte = ASCII_LF;
        if (xfer) begin
          state_next      = IDLE;
          frame_done_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      ch_idx_reg     <= '0;
      dig_idx_reg    <= '0;
      cksum_reg      <= 8'h00;
      ch_snap_reg    <= '0;
      dot_snap_reg   <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ch_idx_reg     <= ch_idx_next;
      dig_idx_reg    <= dig_idx_next;
      cksum_reg      <= cksum_next;
      frame_done_reg <= frame_done_next;
      if (load_snap) begin
        ch_snap_reg  <= ch_data;
        dot_snap_reg <= dot_en;
      end
    end
  end

endmodule

// File: tb/tb_telemetry_framer.sv
// Self-checking bench: byte scoreboard fed by a frame model, table of frames,
// stall/restart/reset corner sequences, a no-dot single-channel instance, and random frames.
module tb_telemetry_framer;

  localparam int NC = 2;
  localparam int DG = 4;
  localparam int DP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [NC*DG*8-1:0] ch_data = '0;
  logic [NC-1:0]     dot_en = '0;
  logic              tx_ready = 1'b1;
  logic [7:0]        tx_data;
  logic              tx_valid, busy, frame_done;

  logic              start1 = 1'b0;
  logic [23:0]       ch_data1 = '0;
  logic [0:0]        dot_en1 = '0;
  logic              tx_ready1 = 1'b1;
  logic [7:0]        tx_data1;
  logic              tx_valid1, busy1, frame_done1;

  telemetry_framer #(.NUM_CH(NC), .DIGITS(DG), .DOT_POS(DP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ch_data(ch_data), .dot_en(dot_en),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .frame_done(frame_done)
  );

  telemetry_framer #(.NUM_CH(1), .DIGITS(3), .DOT_POS(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .ch_data(ch_data1), .dot_en(dot_en1),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1), .busy(busy1),
    .frame_done(frame_done1)
  );

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  bit         expect_done = 0;
  bit         done_seen = 0;
  bit         prev_hold = 0;
  logic [7:0] prev_data = 8'h00;
  int         first_cyc = 0;
  int         last_cyc = 0;

  logic [7:0] exp1 [10] = '{8'h28, 8'h37, 8'h30, 8'h35, 8'h29, 8'h2A, 8'h33, 8'h33, 8'h0D, 8'h0A};

  typedef struct {
    logic [NC*DG*8-1:0] d;
    logic [NC-1:0]      de;
    int                 len;
    logic [7:0]         ck_hi;
    logic [7:0]         ck_lo;
  } vec_t;
  vec_t tbl[5];

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %02h expected %02h", name, got, exp);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
  endfunction

  function automatic logic [NC*DG*8-1:0] pack_ch(input logic [31:0] s0, input logic [31:0] s1);
    logic [NC*DG*8-1:0] r;
    logic [31:0] s;
    r = '0;
    for (int c = 0; c < NC; c++) begin
      s = (c == 0) ? s0 : s1;
      for (int k = 0; k < DG; k++) r[(c*DG+k)*8 +: 8] = s[(DG-1-k)*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [7:0] calc_ck(input logic [NC*DG*8-1:0] data, input logic [NC-1:0] de);
    logic [7:0] ck;
    ck = 8'h00;
    for (int c = 0; c < NC; c++) begin
      ck ^= 8'h28 ^ 8'h29;
      if (de[c] && DP > 0) ck ^= 8'h2E;
      for (int k = 0; k < DG; k++) ck ^= data[(c*DG+k)*8 +: 8];
    end
    return ck;
  endfunction

  function automatic void push_frame(input logic [NC*DG*8-1:0] data, input logic [NC-1:0] de);
    logic [7:0] ck;
    ck = calc_ck(data, de);
    for (int c = 0; c < NC; c++) begin
      exp_q.push_back(8'h28);
      for (int k = 0; k < DG; k++) begin
        if (de[c] && DP > 0 && k == DG - DP) exp_q.push_back(8'h2E);
        exp_q.push_back(data[(c*DG+k)*8 +: 8]);
      end
      exp_q.push_back(8'h29);
    end
    exp_q.push_back(8'h2A);
    exp_q.push_back(hexc(ck[7:4]));
    exp_q.push_back(hexc(ck[3:0]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  // Scoreboard monitor: samples on the falling edge, ahead of the transfer edge.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst_n) begin
      prev_hold   = 0;
      expect_done = 0;
    end else begin
      if (expect_done) begin
        check_int("done_pulse_busy_valid", {frame_done, busy, tx_valid}, 3'b100);
        expect_done = 0;
        done_seen   = 1;
      end else if (frame_done) begin
        check_int("spurious_frame_done", 1, 0);
      end
      if (prev_hold) begin
        check_int("hold_valid", tx_valid, 1);
        check8("hold_data", tx_data, prev_data);
      end
      if (tx_valid && tx_ready) begin
        rx_q.push_back(tx_data);
        if (rx_q.size() == 1) first_cyc = cyc;
        last_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_byte: got %02h expected no transfer", tx_data);
        end else begin
          e = exp_q.pop_front();
          check8("byte", tx_data, e);
          if (exp_q.size() == 0) expect_done = 1;
        end
      end
      prev_hold = tx_valid && !tx_ready;
      prev_data = tx_data;
    end
  end

  task automatic send(input logic [NC*DG*8-1:0] d, input logic [NC-1:0] de);
    rx_q.delete();
    done_seen = 0;
    ch_data   = d;
    dot_en    = de;
    start     = 1'b1;
    push_frame(d, de);
    @(posedge clk); #1;
    start = 1'b0;
    check8("first_byte", tx_data, 8'h28);
    check_int("first_valid_busy", {tx_valid, busy}, 2'b11);
  endtask

  task automatic wait_done(input int budget, input bit rnd, input bit poke);
    int n;
    n = 0;
    while (!done_seen && n < budget) begin
      @(posedge clk); #1;
      n++;
      if (rnd) tx_ready = ($urandom_range(0, 3) != 0);
      start = poke && tx_valid && (tx_data == 8'h2E || tx_data == 8'h0A);
    end
    start = 1'b0;
    if (!done_seen) begin
      checks++;
      $display("FAIL frame_timeout: no frame_done within %0d cycles", budget);
    end
  endtask

  task automatic check_frame(input string name, input int len, input logic [7:0] hi, input logic [7:0] lo);
    int n;
    n = rx_q.size();
    check_int({name, "_len"}, n, len);
    check8({name, "_ck_hi"}, (n >= 4) ? rx_q[n-4] : 8'h00, hi);
    check8({name, "_ck_lo"}, (n >= 3) ? rx_q[n-3] : 8'h00, lo);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [NC*DG*8-1:0] d;
    logic [NC-1:0]      de;
    logic [7:0]         ck;
    int                 len;

    tbl[0] = '{pack_ch("1234", "0056"), 2'b01, 18, "2", "9"};
    tbl[1] = '{pack_ch("0000", "0000"), 2'b00, 17, "0", "0"};
    tbl[2] = '{pack_ch("1000", "0000"), 2'b01, 18, "2", "F"};
    tbl[3] = '{pack_ch("5000", "0000"), 2'b11, 19, "0", "5"};
    tbl[4] = '{pack_ch("9876", "5432"), 2'b10, 18, "2", "E"};

    // Reset state
    #12;
    check_int("reset_outputs", {tx_valid, busy, frame_done}, 0);
    check8("reset_tx_data", tx_data, 8'h00);
    check_int("reset_outputs_dut1", {tx_valid1, busy1, frame_done1}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset released");

    // Table of frames with tx_ready held high
    for (int i = 0; i < 5; i++) begin
      send(tbl[i].d, tbl[i].de);
      wait_done(100, 0, 0);
      check_frame("table", tbl[i].len, tbl[i].ck_hi, tbl[i].ck_lo);
      check_int("no_bubble", last_cyc - first_cyc, tbl[i].len - 1);
      $display("table frame %0d: %0d bytes, checksum %s%s", i, rx_q.size(), tbl[i].ck_hi, tbl[i].ck_lo);
    end

    // Back-pressure while the decimal point is presented
    send(tbl[0].d, tbl[0].de);
    for (int i = 0; i < 20; i++) begin
      if (tx_data == 8'h2E) break;
      @(posedge clk); #1;
    end
    check8("stall_on_dot", tx_data, 8'h2E);
    tx_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check8("stall_still_dot", tx_data, 8'h2E);
    tx_ready = 1'b1;
    wait_done(100, 0, 0);
    check_frame("stall", 18, "2", "9");
    $display("stall frame: %0d bytes", rx_q.size());

    // Inputs change after start; start re-pulsed mid-frame and on the final transfer
    send(tbl[0].d, tbl[0].de);
    ch_data = pack_ch("9999", "9999");
    dot_en  = 2'b10;
    wait_done(100, 0, 1);
    check_frame("restart", 18, "2", "9");
    repeat (20) @(posedge clk);
    #1;
    check_int("restart_single_frame", {busy, tx_valid}, 0);
    $display("restart-ignore frame: %0d bytes", rx_q.size());

    // Reset during byte 7 aborts the frame
    send(tbl[2].d, tbl[2].de);
    repeat (6) @(posedge clk);
    #1;
    check8("byte7_before_reset", tx_data, 8'h29);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_int("abort_valid_busy", {tx_valid, busy}, 0);
    check8("abort_tx_data", tx_data, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_int("idle_after_reset", {tx_valid, busy}, 0);
    send(tbl[4].d, tbl[4].de);
    wait_done(100, 0, 0);
    check_frame("post_reset", 18, "2", "E");
    $display("post-reset frame: %0d bytes", rx_q.size());

    // Single channel, no decimal point even though enabled
    ch_data1 = {8'h35, 8'h30, 8'h37};
    dot_en1  = 1'b1;
    start1   = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check_int("dut1_valid", tx_valid1, 1);
      check8("dut1_byte", tx_data1, exp1[i]);
      @(posedge clk); #1;
    end
    check_int("dut1_done", {frame_done1, busy1, tx_valid1}, 3'b100);
    @(posedge clk); #1;
    check_int("dut1_done_one_cycle", frame_done1, 0);
    $display("single-channel no-dot frame: 10 bytes");

    // Random frames with random back-pressure; the first 256 force every checksum value
    for (int f = 0; f < 1000; f++) begin
      for (int b = 0; b < NC*DG; b++) begin
        if (f < 256 || f[0]) d[b*8 +: 8] = 8'($urandom_range(0, 255));
        else d[b*8 +: 8] = 8'h30 + 8'($urandom_range(0, 9));
      end
      de = NC'($urandom_range(0, 3));
      if (f < 256) begin
        ck = calc_ck(d, de);
        d[NC*DG*8-1 -: 8] = d[NC*DG*8-1 -: 8] ^ ck ^ 8'(f);
      end
      ck  = calc_ck(d, de);
      len = NC*(DG+2) + 5 + int'(de[0]) + int'(de[1]);
      send(d, de);
      wait_done(2000, 1, 0);
      tx_ready = 1'b1;
      check_frame("random", len, hexc(ck[7:4]), hexc(ck[3:0]));
      $display("random frame %0d: %0d bytes, checksum %02h", f, rx_q.size(), ck);
    end

    repeat (3) @(posedge clk);
    check_int("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
